mem_delay_queue: RTL
====================

// Module: mem_delay_queue
// PURPOSE
//   Parametrised successor to the single-slot memory delay model. Sits between core and memory on the
//   memory_io_req/memory_io_rsp path and models a slow memory. Buffers up to DEPTH outstanding requests,
//   each delayed by REQ_DELAY cycles plus optional LFSR jitter, and issues them to memory strictly in order.
//   Also delays memory responses by a fixed RSP_DELAY. Reports queue overflow and dropped requests.
// PARAMETERS
//   DEPTH        4       request queue entries (>=1, power of two)
//   REQ_DELAY    4       base request delay in cycles (>=0)
//   RSP_DELAY    0       response delay in cycles (>=0; 0 = combinational pass-through)
//   JITTER_EN    0       1 = add pseudo-random jitter to each request's delay
//   JITTER_BITS  2       jitter = lfsr[JITTER_BITS-1:0], range 0..2^JITTER_BITS-1 (1..15)
//   LFSR_SEED    16'hACE1  non-zero reset value of the 16-bit LFSR (x^16+x^14+x^13+x^11+1)
// PORTS
//   clk          in   1                 clock
//   reset        in   1                 async, active-low reset
//   from_core    in   memory_io_req     request from core; valid field qualifies
//   to_core      out  memory_io_rsp     delayed response to core
//   to_memory    out  memory_io_req     delayed request to memory
//   from_memory  in   memory_io_rsp     response from memory; valid field qualifies
//   stat_clear   in   1                 sync clear of overflow and drop_count
//   occupancy    out  $clog2(DEPTH)+1   entries currently queued
//   full         out  1                 occupancy == DEPTH
//   overflow     out  1                 sticky: at least one request dropped
//   drop_count   out  16                dropped requests, saturates at 16'hFFFF
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Reset (reset==0): queue emptied, all countdowns 0, LFSR=LFSR_SEED.
//     Response pipe flushed. to_memory=memory_io_no_req, to_core=memory_io_no_rsp.
//     occupancy=0, full=0, overflow=0, drop_count=0.
//     Asserting reset mid-operation discards all queued requests and in-flight responses.
//     No partial issue after release.
//   Enqueue: on an edge with from_core.valid, the request is written at tail.
//     Countdown = REQ_DELAY + (JITTER_EN ? lfsr[JITTER_BITS-1:0] : 0).
//     The LFSR advances once per accepted request only.
//   Countdown: every entry with countdown>0 decrements by 1 each cycle, saturating at 0.
//   Issue: to_memory = head entry (combinational from head) when occupancy>0 and head countdown==0.
//     Otherwise memory_io_no_req. Memory is always ready, so the head pops at that edge.
//     At most one issue per cycle.
//   Latency (no jitter, empty queue): from_core.valid in cycle 0 -> to_memory.valid in cycle REQ_DELAY+1.
//   Ordering: strict FIFO. A younger entry whose countdown reaches 0 waits behind a non-zero head.
//     Issue timing of an entry = max(own expiry, previous issue + 1).
//   Full: from_core.valid while full and no pop that cycle -> request dropped.
//     On a drop: overflow<=1, drop_count+=1 (saturating), LFSR not advanced.
//     Push and pop in the same cycle while full -> accepted, occupancy unchanged.
//   Stats: stat_clear -> overflow<=0, drop_count<=0.
//     Drop in the same cycle as stat_clear -> overflow=1, drop_count=1.
//   Responses: RSP_DELAY==0 -> to_core = from_memory.valid ? from_memory : memory_io_no_rsp.
//     RSP_DELAY>0 -> RSP_DELAY-stage shift register; one response per cycle, back-to-back, order kept.
//     Empty stages hold memory_io_no_rsp. No response buffering beyond the pipe; no backpressure.
//   Pointers: head/tail wrap modulo DEPTH.
//     occupancy tracks push-minus-pop exactly; full/empty never aliased.
// TESTING
//   T1 DEPTH=4, REQ_DELAY=4, JITTER_EN=0: single req at cycle 0 (addr 0x100) -> to_memory.valid only at cycle 5.
//   T2 4 reqs on cycles 0-3 -> issued cycles 5,6,7,8 in order; occupancy peaks at 4; full=1 during cycles 4-5.
//   T3 5 back-to-back reqs at cycles 0-4, no pop before cycle 5 -> 5th dropped;
//      overflow=1, drop_count=1; stat_clear then -> both 0.
//   T4 JITTER_EN=1, JITTER_BITS=2, LFSR_SEED=16'hACE1 -> issue cycles match a reference LFSR model;
//      no issue earlier than 5 cycles after enqueue, FIFO order holds.
//   T5 RSP_DELAY=3: from_memory.valid at cycles 10,11 -> to_core.valid at 13,14, data unchanged;
//      RSP_DELAY=0 -> same cycle.
//   T6 reset pulled low at cycle 3 with 2 queued and 1 response in pipe
//      -> no to_memory/to_core valid afterwards; occupancy=0 immediately (async).

Source files
------------

// File: rtl/mem_delay_queue.sv
// Slow-memory model: an in-order request delay queue with optional LFSR jitter,
// a fixed-latency response pipe, and drop/overflow statistics.
package mem_delay_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } memory_io_rsp;

  localparam memory_io_req memory_io_no_req = '0;
  localparam memory_io_rsp memory_io_no_rsp = '0;
endpackage

module mem_delay_queue
  import mem_delay_queue_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter int          REQ_DELAY   = 4,
  parameter int          RSP_DELAY   = 0,
  parameter int          JITTER_EN   = 0,
  parameter int          JITTER_BITS = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  memory_io_req           from_core_i,
  output memory_io_rsp           to_core_o,
  output memory_io_req           to_memory_o,
  input  memory_io_rsp           from_memory_i,
  input  logic                   stat_clear_i,
  output logic [$clog2(DEPTH):0] occupancy_o,
  output logic                   full_o,
  output logic                   overflow_o,
  output logic [15:0]            drop_count_o
);

  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW      = $clog2(DEPTH) + 1;
  localparam int MAX_CNT = REQ_DELAY + ((JITTER_EN != 0) ? ((1 << JITTER_BITS) - 1) : 0);
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT + 1) : 1;

  memory_io_req  entry_q [DEPTH];
  logic [CW-1:0] cnt_q   [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_q, drop_d;
  logic          pop, push, drop;
  logic [CW-1:0] cnt_load;
  logic          lfsr_fb;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full_o = (occ_q == OW'(DEPTH));

  always_comb begin
    pop      = (occ_q != '0) && (cnt_q[head_q] == '0);
    push     = from_core_i.valid && (!full_o || pop);
    drop     = from_core_i.valid && !push;
    head_d   = pop  ? nextPtr(head_q) : head_q;
    tail_d   = push ? nextPtr(tail_q) : tail_q;
    occ_d    = occ_q;
    if (push && !pop) occ_d = occ_q + 1'b1;
    if (pop && !push) occ_d = occ_q - 1'b1;
    cnt_load = CW'(REQ_DELAY);
    if (JITTER_EN != 0) cnt_load = cnt_load + CW'(lfsr_q[JITTER_BITS-1:0]);
    lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d   = push ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
    // A drop wins over a simultaneous clear so the event is never lost.
    ovf_d    = stat_clear_i ? 1'b0 : ovf_q;
    drop_d   = stat_clear_i ? 16'h0000 : drop_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_d != 16'hFFFF) drop_d = drop_d + 16'h0001;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      lfsr_q <= LFSR_SEED;
      ovf_q  <= 1'b0;
      drop_q <= 16'h0000;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      lfsr_q <= lfsr_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= memory_io_no_req;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (tail_q == PW'(i))) begin
          entry_q[i] <= from_core_i;
          cnt_q[i]   <= cnt_load;
        end else if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  assign to_memory_o  = pop ? entry_q[head_q] : memory_io_no_req;
  assign occupancy_o  = occ_q;
  assign overflow_o   = ovf_q;
  assign drop_count_o = drop_q;

  // Responses are never stalled; a nonzero delay is a plain shift register.
  if (RSP_DELAY == 0) begin : g_rsp_comb
    assign to_core_o = from_memory_i.valid ? from_memory_i : memory_io_no_rsp;
  end else begin : g_rsp_pipe
    memory_io_rsp pipe_q [RSP_DELAY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < RSP_DELAY; i++) pipe_q[i] <= memory_io_no_rsp;
      end else begin
        pipe_q[0] <= from_memory_i.valid ? from_memory_i : memory_io_no_rsp;
        for (int i = 1; i < RSP_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign to_core_o = pipe_q[RSP_DELAY-1];
  end

endmodule
